// File: rtl/hqm_rcfwl_gclk_pkg.sv
// hqm_rcfwl_gclk_pkg
//   Shared definitions for the grid-side PLL sync alignment logic:
//   - sync_state_t : alignment FSM states
//   - GOOD_W       : width of the consecutive on-time edge counter
//   - params_ok()  : elaboration-time legality check of the block parameters
package hqm_rcfwl_gclk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } sync_state_t;

    // LOCK_CNT is limited to 1..15, so four bits always hold it.
    localparam int GOOD_W = 4;

    // The divided enable must land on the same phases every sync period,
    // so the period has to be a whole multiple of the divide ratio.
    function automatic bit params_ok(input int sync_period, input int div,
                                     input int lock_cnt, input int sync_stages);
        bit ok;
        ok = (sync_period >= 4) && (div >= 1) && (lock_cnt >= 1) &&
             (lock_cnt <= 15) && (sync_stages >= 2);
        if (ok) begin
            ok = ((sync_period % div) == 0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_sync_edge.sv
// hqm_rcfwl_gclk_sync_edge
//   Multi-flop synchronizer followed by a registered rising-edge detector.
//   Fixed latency: pulse rises SYNC_STAGES+1 cycles after din rises; a level
//   held high yields a single one-cycle pulse.
// Ports
//   ckgrid  in   sampling clock
//   rst_b   in   synchronous active-low reset
//   din     in   asynchronous input level
//   pulse   out  one-cycle registered pulse per rising edge of din
module hqm_rcfwl_gclk_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ckgrid,
    input  logic rst_b,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic                   pulse_q, pulse_d;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        last_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~last_q;
    end

    // NOTE: state flops use non-blocking assignments so all registers update
    // from pre-edge values, exactly like the hardware does.
    always_ff @(posedge ckgrid) begin
        if (!rst_b) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            last_q  <= last_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/hqm_rcfwl_gclk_pll_sync_align.sv
// hqm_rcfwl_gclk_pll_sync_align
//   Grid-side consumer of the PCU clock distribution. Samples pll_sync on the
//   grid clock, checks its period, and produces a sync-aligned phase count,
//   a divided clock enable, lock status and a sticky sync error.
// Ports
//   ckgrid      in   grid clock
//   rst_b       in   synchronous active-low reset
//   pll_sync    in   PLL sync strobe, asynchronous to ckgrid
//   sync_en     in   1 = acquire/track, 0 = hold in IDLE
//   err_clr     in   clears sync_err (a same-cycle new error wins)
//   sync_pulse  out  one-cycle pulse per detected pll_sync rising edge
//   phase_cnt   out  phase within the sync period, 0 after an aligned edge
//   clk_en      out  pulse when phase_cnt % DIV == DIV-1 in TRACK/LOCKED
//   locked      out  1 while LOCKED
//   sync_err    out  sticky early/missing edge indication while LOCKED
module hqm_rcfwl_gclk_pll_sync_align
    import hqm_rcfwl_gclk_pkg::*;
#(
    parameter  int SYNC_PERIOD = 16,
    parameter  int DIV         = 4,
    parameter  int LOCK_CNT    = 3,
    parameter  int SYNC_STAGES = 2,
    localparam int CNTW        = $clog2(SYNC_PERIOD)
) (
    input  logic            ckgrid,
    input  logic            rst_b,
    input  logic            pll_sync,
    input  logic            sync_en,
    input  logic            err_clr,
    output logic            sync_pulse,
    output logic [CNTW-1:0] phase_cnt,
    output logic            clk_en,
    output logic            locked,
    output logic            sync_err
);

    if (!params_ok(SYNC_PERIOD, DIV, LOCK_CNT, SYNC_STAGES)) begin : g_bad_params
        $error("hqm_rcfwl_gclk_pll_sync_align: illegal SYNC_PERIOD/DIV/LOCK_CNT/SYNC_STAGES");
    end

    localparam logic [CNTW-1:0]   LAST_PHASE = CNTW'(SYNC_PERIOD - 1);
    localparam logic [GOOD_W:0]   LOCK_THR   = (GOOD_W + 1)'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GOOD_MAX   = '1;

    logic edge_seen;

    hqm_rcfwl_gclk_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .ckgrid (ckgrid),
        .rst_b  (rst_b),
        .din    (pll_sync),
        .pulse  (edge_seen)
    );

    sync_state_t       state_q, state_d;
    logic [CNTW-1:0]   phase_cnt_q, phase_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic              clk_en_q, clk_en_d;
    logic              locked_q, locked_d;
    logic              sync_err_q, sync_err_d;

    logic              at_last;
    logic [CNTW-1:0]   phase_next;
    logic              realign;
    logic              err_set;

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        good_cnt_d  = good_cnt_q;
        realign     = 1'b0;
        err_set     = 1'b0;

        at_last    = (phase_cnt_q == LAST_PHASE);
        phase_next = at_last ? '0 : phase_cnt_q + 1'b1;

        if (!sync_en) begin
            state_d     = IDLE;
            phase_cnt_d = '0;
            good_cnt_d  = '0;
        end else begin
            unique case (state_q)
                // An edge arriving in the enabling cycle is deliberately ignored.
                IDLE: begin
                    state_d     = SEARCH;
                    phase_cnt_d = '0;
                end
                SEARCH: begin
                    phase_cnt_d = '0;
                    if (edge_seen) begin
                        state_d    = TRACK;
                        good_cnt_d = '0;
                        realign    = 1'b1;
                    end
                end
                TRACK: begin
                    phase_cnt_d = phase_next;
                    if (edge_seen && at_last) begin
                        good_cnt_d = (good_cnt_q == GOOD_MAX) ? good_cnt_q : good_cnt_q + 1'b1;
                        if (({1'b0, good_cnt_q} + 1'b1) >= LOCK_THR) begin
                            state_d = LOCKED;
                        end
                    end else if (edge_seen) begin
                        phase_cnt_d = '0;
                        good_cnt_d  = '0;
                        realign     = 1'b1;
                    end else if (at_last) begin
                        good_cnt_d = '0;
                        state_d    = SEARCH;
                    end
                end
                LOCKED: begin
                    phase_cnt_d = phase_next;
                    if (edge_seen && !at_last) begin
                        phase_cnt_d = '0;
                        good_cnt_d  = '0;
                        realign     = 1'b1;
                        err_set     = 1'b1;
                        state_d     = TRACK;
                    end else if (!edge_seen && at_last) begin
                        good_cnt_d = '0;
                        err_set    = 1'b1;
                        state_d    = SEARCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Set beats clear so an error coincident with err_clr is never lost.
        if (err_set) begin
            sync_err_d = 1'b1;
        end else if (err_clr) begin
            sync_err_d = 1'b0;
        end else begin
            sync_err_d = sync_err_q;
        end

        locked_d = (state_d == LOCKED);
        clk_en_d = ((state_d == TRACK) || (state_d == LOCKED)) && !realign &&
                   ((int'(phase_cnt_d) % DIV) == (DIV - 1));
    end

    always_ff @(posedge ckgrid) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            phase_cnt_q <= '0;
            good_cnt_q  <= '0;
            clk_en_q    <= 1'b0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            good_cnt_q  <= good_cnt_d;
            clk_en_q    <= clk_en_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign sync_pulse = edge_seen;
    assign phase_cnt  = phase_cnt_q;
    assign clk_en     = clk_en_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_pll_sync_align.sv
// Testbench for hqm_rcfwl_gclk_pll_sync_align with default parameters
// (SYNC_PERIOD=16, DIV=4, LOCK_CNT=3, SYNC_STAGES=2).
// Each table row: optionally pulse pll_sync and/or err_clr for one cycle,
// advance 'gap' cycles in total, then compare all outputs with hand-computed
// values. Comments give the cycle count relative to the first table pulse.
module tb_hqm_rcfwl_gclk_pll_sync_align;

    logic       ckgrid = 1'b0;
    logic       rst_b;
    logic       pll_sync;
    logic       sync_en;
    logic       err_clr;
    logic       sync_pulse;
    logic [3:0] phase_cnt;
    logic       clk_en;
    logic       locked;
    logic       sync_err;

    int total = 0;
    int bad   = 0;

    hqm_rcfwl_gclk_pll_sync_align dut (
        .ckgrid     (ckgrid),
        .rst_b      (rst_b),
        .pll_sync   (pll_sync),
        .sync_en    (sync_en),
        .err_clr    (err_clr),
        .sync_pulse (sync_pulse),
        .phase_cnt  (phase_cnt),
        .clk_en     (clk_en),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 ckgrid = ~ckgrid;

    typedef struct {
        bit         pulse;
        bit         clr;
        int         gap;
        bit         sp;
        logic [3:0] ph;
        bit         ce;
        bit         lk;
        bit         er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit pulse, input bit clr, input int gap,
                                input bit sp, input int ph, input bit ce,
                                input bit lk, input bit er);
        vec_t v;
        v.pulse = pulse; v.clr = clr; v.gap = gap;
        v.sp = sp; v.ph = 4'(ph); v.ce = ce; v.lk = lk; v.er = er;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit sp, input int ph,
                              input bit ce, input bit lk, input bit er);
        check({tag, ".sync_pulse"}, 32'(sync_pulse), 32'(sp));
        check({tag, ".phase_cnt"},  32'(phase_cnt),  32'(ph));
        check({tag, ".clk_en"},     32'(clk_en),     32'(ce));
        check({tag, ".locked"},     32'(locked),     32'(lk));
        check({tag, ".sync_err"},   32'(sync_err),   32'(er));
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge ckgrid);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;

        // Reset held with pll_sync toggling: everything stays 0.
        rst_b = 1'b0; sync_en = 1'b1; err_clr = 1'b0; pll_sync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pll_sync = ~pll_sync;
            tick();
            check_outs($sformatf("rst%0d", i), 0, 0, 0, 0, 0);
        end
        rst_b = 1'b1; sync_en = 1'b0; pll_sync = 1'b0;
        repeat (4) tick();
        check_outs("idle", 0, 0, 0, 0, 0);

        // Level held high gives one pulse at fixed latency; enabling in the
        // pulse cycle must not acquire (phase stays 0 in SEARCH).
        pll_sync = 1'b1;
        tick(); tick();
        check("lat.pre", 32'(sync_pulse), 32'd0);
        tick();
        check("lat.edge", 32'(sync_pulse), 32'd1);
        sync_en = 1'b1;
        pulses = 1;
        repeat (5) begin
            tick();
            if (sync_pulse) pulses++;
        end
        check("held.pulses", 32'(pulses), 32'd1);
        check_outs("en_edge", 0, 0, 0, 0, 0);
        pll_sync = 1'b0;
        repeat (4) tick();

        // Acquire and lock.
        add(1,0, 3, 1, 0,0,0,0); // c3   edge seen in SEARCH
        add(0,0, 1, 0, 0,0,0,0); // c4   TRACK, phase 0
        add(0,0, 3, 0, 3,1,0,0); // c7
        add(0,0, 1, 0, 4,0,0,0); // c8
        add(0,0, 8, 0,12,0,0,0); // c16
        add(1,0, 3, 1,15,1,0,0); // c19  on-time 1
        add(0,0,13, 0,12,0,0,0); // c32
        add(1,0, 3, 1,15,1,0,0); // c35  on-time 2
        add(0,0,13, 0,12,0,0,0); // c48
        add(1,0, 3, 1,15,1,0,0); // c51  on-time 3
        add(0,0, 1, 0, 0,0,1,0); // c52  locked
        // Early edge while LOCKED (12 cycles after previous pulse).
        add(0,0, 8, 0, 8,0,1,0); // c60
        add(1,0, 3, 1,11,1,1,0); // c63  early edge at phase 11
        add(0,0, 1, 0, 0,0,0,1); // c64  realigned, error, TRACK
        add(0,0,12, 0,12,0,0,1); // c76
        add(1,0, 3, 1,15,1,0,1); // c79
        add(0,0,13, 0,12,0,0,1); // c92
        add(1,0, 3, 1,15,1,0,1); // c95
        add(0,0,13, 0,12,0,0,1); // c108
        add(1,0, 3, 1,15,1,0,1); // c111
        add(0,0, 1, 0, 0,0,1,1); // c112 relocked, error still sticky
        add(0,1, 1, 0, 1,0,1,0); // c113 err_clr alone clears
        // Missing edge while LOCKED, with err_clr coincident with the error.
        add(0,0,14, 0,15,1,1,0); // c127
        add(0,1, 1, 0, 0,0,0,1); // c128 set wins over clear, SEARCH
        add(0,0, 1, 0, 0,0,0,1); // c129 sticky
        add(0,0, 2, 0, 0,0,0,1); // c131 SEARCH: no clk_en, phase held
        add(1,0, 3, 1, 0,0,0,1); // c134
        add(0,0, 1, 0, 0,0,0,1); // c135 TRACK restarted
        add(0,0, 3, 0, 3,1,0,1); // c138
        add(0,0, 9, 0,12,0,0,1); // c147
        add(1,0, 3, 1,15,1,0,1); // c150
        add(0,0,13, 0,12,0,0,1); // c163
        add(1,0, 3, 1,15,1,0,1); // c166
        add(0,0,13, 0,12,0,0,1); // c179
        add(1,0, 3, 1,15,1,0,1); // c182
        add(0,0, 1, 0, 0,0,1,1); // c183 locked again
        add(0,0, 3, 0, 3,1,1,1); // c186

        foreach (vecs[i]) begin
            pll_sync = vecs[i].pulse;
            err_clr  = vecs[i].clr;
            tick();
            pll_sync = 1'b0;
            err_clr  = 1'b0;
            for (int k = 1; k < vecs[i].gap; k++) tick();
            check_outs($sformatf("v%0d", i), vecs[i].sp, int'(vecs[i].ph),
                       vecs[i].ce, vecs[i].lk, vecs[i].er);
        end

        // sync_en dropped mid-LOCKED: cleared next cycle, sync_err retained.
        sync_en = 1'b0;
        tick();
        check_outs("dis", 0, 0, 0, 0, 1);
        tick();
        check_outs("dis2", 0, 0, 0, 0, 1);

        // Re-acquire, then reset mid-operation.
        sync_en = 1'b1;
        tick();
        pll_sync = 1'b1;
        tick();
        pll_sync = 1'b0;
        tick(); tick();
        check("reacq.edge", 32'(sync_pulse), 32'd1);
        repeat (6) tick();
        check_outs("reacq", 0, 5, 0, 0, 1);
        rst_b = 1'b0;
        tick();
        check_outs("midrst", 0, 0, 0, 0, 0);
        rst_b = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
